// File: rtl/pueo_beam_v4_pkg.sv
// Shared widths, constants and helpers for the beamforming power trigger.
package pueo_beam_v4_pkg;

    function automatic int unsigned sum_width(input int unsigned nchan, input int unsigned nbits);
        return $clog2(nchan * ((32'd1 << nbits) - 32'd1) + 32'd1) + 1;
    endfunction

    function automatic int unsigned square_width(input int unsigned sw);
        return 2 * sw;
    endfunction

    function automatic int unsigned delay_width(input int unsigned depth, input int unsigned nsamp);
        return $clog2((depth - 1) * nsamp + 1);
    endfunction

    function automatic int unsigned mid_code(input int unsigned nbits);
        return 32'd1 << (nbits - 1);
    endfunction

    function automatic logic [63:0] saturate(input logic [63:0] value, input int unsigned bits);
        logic [63:0] max_val;
        max_val = (64'd1 << bits) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/beam_power_unit.sv
// One beam: delay mux, coherent doubled sum, square, accumulate, threshold and holdoff.
module beam_power_unit
    import pueo_beam_v4_pkg::*;
#(
    parameter int unsigned NCHAN       = 8,
    parameter int unsigned NBITS       = 5,
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned THRESH_BITS = 24,
    parameter int unsigned HOLDOFF     = 16,
    localparam int unsigned DW         = delay_width(DEPTH, NSAMP)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCHAN-1:0][DEPTH*NSAMP*NBITS-1:0] hist,
    input  logic [NCHAN-1:0][DW-1:0]               delay,
    input  logic [THRESH_BITS-1:0]                 thresh,
    input  logic                                   mask,
    output logic                                   trigger,
    output logic [THRESH_BITS-1:0]                 power
);
    localparam int unsigned WW   = NSAMP * NBITS;
    localparam int unsigned MAXD = (DEPTH - 1) * NSAMP;
    localparam int unsigned XW   = NBITS + 1;
    localparam int unsigned SW   = sum_width(NCHAN, NBITS);
    localparam int unsigned QW   = square_width(SW);
    localparam int unsigned AW   = QW + $clog2(NSAMP) + 1;
    localparam int unsigned HW   = $clog2(HOLDOFF + 2);

    logic signed [XW-1:0] win_d [NCHAN][NSAMP];
    logic signed [XW-1:0] win_q [NCHAN][NSAMP];
    logic signed [SW-1:0] sum_d [NSAMP];
    logic signed [SW-1:0] sum_q [NSAMP];
    logic [QW-1:0]        sq_d  [NSAMP];
    logic [QW-1:0]        sq_q  [NSAMP];
    logic [AW-1:0]        acc;
    logic [HW-1:0]        hold_q;
    logic                 fire;
    logic [WW-1:0]        word;
    logic [NBITS-1:0]     code;
    int unsigned          dsel;
    logic signed [QW-1:0] ext;

    // Window of NSAMP samples ending 'delay' samples before the newest; stored as 2v+1-2^NBITS
    always_comb begin
        word = '0;
        code = '0;
        dsel = 0;
        for (int c = 0; c < NCHAN; c++) begin
            dsel = (32'(delay[c]) > MAXD) ? MAXD : 32'(delay[c]);
            word = WW'(hist[c] >> ((MAXD - dsel) * NBITS));
            for (int s = 0; s < NSAMP; s++) begin
                code        = NBITS'(word >> (32'(s) * NBITS));
                // flipping the MSB of {code,1} subtracts 2^NBITS in two's complement
                win_d[c][s] = {~code[NBITS-1], code[NBITS-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        ext = '0;
        acc = '0;
        for (int s = 0; s < NSAMP; s++) begin
            sum_d[s] = '0;
            for (int c = 0; c < NCHAN; c++) begin
                sum_d[s] = sum_d[s] + SW'(win_q[c][s]);
            end
            ext      = QW'(sum_q[s]);
            sq_d[s]  = ext * ext;
            acc      = acc + AW'(sq_q[s]);
        end
    end

    assign fire = (power > thresh) && !mask && (hold_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '{default: '0};
            sum_q   <= '{default: '0};
            sq_q    <= '{default: '0};
            power   <= '0;
            trigger <= 1'b0;
            hold_q  <= '0;
        end else begin
            win_q   <= win_d;
            sum_q   <= sum_d;
            sq_q    <= sq_d;
            power   <= THRESH_BITS'(saturate(64'(acc), THRESH_BITS));
            trigger <= fire;
            if (fire) begin
                hold_q <= HW'(HOLDOFF);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end
        end
    end

endmodule

// File: rtl/beamform_trigger_v4.sv
// Beamforming power trigger: shared sample store, shadow/active config banks, per-beam units.
module beamform_trigger_v4
    import pueo_beam_v4_pkg::*;
#(
    parameter int unsigned NCHAN       = 8,
    parameter int unsigned NBITS       = 5,
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NBEAMS      = 16,
    parameter int unsigned THRESH_BITS = 24,
    parameter int unsigned HOLDOFF     = 16,
    localparam int unsigned DW         = delay_width(DEPTH, NSAMP),
    localparam int unsigned BW         = $clog2(NBEAMS),
    localparam int unsigned CW         = $clog2(NCHAN)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NCHAN-1:0][NSAMP*NBITS-1:0]   data_i,
    input  logic                                cfg_wr_i,
    input  logic [BW-1:0]                       cfg_beam_i,
    input  logic [CW-1:0]                       cfg_chan_i,
    input  logic [DW-1:0]                       cfg_delay_i,
    input  logic                                cfg_update_i,
    input  logic                                thresh_wr_i,
    input  logic [BW-1:0]                       thresh_beam_i,
    input  logic [THRESH_BITS-1:0]              thresh_i,
    input  logic                                thresh_update_i,
    input  logic [NBEAMS-1:0]                   beam_mask_i,
    output logic [NBEAMS-1:0]                   trigger_o,
    output logic [NBEAMS-1:0][THRESH_BITS-1:0]  power_o
);
    localparam int unsigned WW       = NSAMP * NBITS;
    localparam int unsigned STORE_W  = (DEPTH - 1) * WW;
    localparam int unsigned MAXD     = (DEPTH - 1) * NSAMP;
    localparam logic [NBITS-1:0] MID = NBITS'(mid_code(NBITS));

    logic [NCHAN-1:0][STORE_W-1:0]            store_q;
    logic [NCHAN-1:0][DEPTH*WW-1:0]           hist;
    logic [NBEAMS-1:0][NCHAN-1:0][DW-1:0]     sh_delay_q;
    logic [NBEAMS-1:0][NCHAN-1:0][DW-1:0]     act_delay_q;
    logic [NBEAMS-1:0][THRESH_BITS-1:0]       sh_thresh_q;
    logic [NBEAMS-1:0][THRESH_BITS-1:0]       act_thresh_q;
    logic [DW-1:0]                            delay_clamped;

    // Full history seen by the delay mux: current word on top, oldest stored word at the bottom
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            hist[c] = {data_i[c], store_q[c]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            store_q <= {(NCHAN*(DEPTH-1)*NSAMP){MID}};
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                store_q[c] <= hist[c][DEPTH*WW-1:WW];
            end
        end
    end

    assign delay_clamped = (32'(cfg_delay_i) > MAXD) ? DW'(MAXD) : cfg_delay_i;

    // Update copies the registered shadow, so a same-cycle write lands at the next update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_delay_q   <= '0;
            act_delay_q  <= '0;
            sh_thresh_q  <= '1;
            act_thresh_q <= '1;
        end else begin
            if (cfg_update_i) begin
                act_delay_q <= sh_delay_q;
            end
            if (cfg_wr_i && (32'(cfg_beam_i) < NBEAMS) && (32'(cfg_chan_i) < NCHAN)) begin
                sh_delay_q[cfg_beam_i][cfg_chan_i] <= delay_clamped;
            end
            if (thresh_update_i) begin
                act_thresh_q <= sh_thresh_q;
            end
            if (thresh_wr_i && (32'(thresh_beam_i) < NBEAMS)) begin
                sh_thresh_q[thresh_beam_i] <= thresh_i;
            end
        end
    end

    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        beam_power_unit #(
            .NCHAN      (NCHAN),
            .NBITS      (NBITS),
            .NSAMP      (NSAMP),
            .DEPTH      (DEPTH),
            .THRESH_BITS(THRESH_BITS),
            .HOLDOFF    (HOLDOFF)
        ) u_unit (
            .clk    (clk_i),
            .rst    (rst_i),
            .hist   (hist),
            .delay  (act_delay_q[b]),
            .thresh (act_thresh_q[b]),
            .mask   (beam_mask_i[b]),
            .trigger(trigger_o[b]),
            .power  (power_o[b])
        );
    end

endmodule
